// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the RV32I front end.
// Holds the NOP bubble encoding, the branch counter type and the
// default PHT index width used by the fetch stage.
package riscv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PATTERN_W = 10;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  // Saturating 2-bit counter step: moves toward ST on taken, toward SNT otherwise.
  function automatic bp_cnt_t cnt_step(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t res;
    res = cnt;
    case (cnt)
      SNT:     res = taken ? WNT : SNT;
      WNT:     res = taken ? WT  : SNT;
      WT:      res = taken ? ST  : WNT;
      ST:      res = taken ? ST  : WT;
      default: res = WNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bpred_gshare.sv
// Branch predictor for the fetch stage: PHT of 2-bit counters, direct-mapped
// BTB and (optionally) a global history register.
// Build option FETCH_GSHARE_EN: when defined the PHT index is PC bits XOR the
// GHR (gshare); otherwise the index is the PC bits alone (bimodal) and no GHR
// exists. The update interface is identical in both builds.
// Lookup reads registered state only, so a same-cycle update is seen next cycle.
module bpred_gshare
  import riscv_pipe_pkg::*;
#(
  parameter int HIST_W      = PATTERN_W,
  parameter int BTB_ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       lookup_pc,
  output logic [HIST_W-1:0] lookup_idx,
  output logic              lookup_taken,
  output logic [31:0]       lookup_target,
  input  logic              upd_vld,
  input  logic              upd_taken,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  input  logic [HIST_W-1:0] upd_pattern
);

  localparam int BTB_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - 2 - BTB_W;
  localparam int PHT_N = 1 << HIST_W;

  bp_cnt_t                pht     [PHT_N];
  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [31:0]            btb_tgt [BTB_ENTRIES];

  logic [BTB_W-1:0] look_bi;
  logic [BTB_W-1:0] upd_bi;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] upd_tag;
  logic [1:0]       look_cnt;
  logic             btb_hit;
  logic             unused_ok;

  assign look_bi  = lookup_pc[2 +: BTB_W];
  assign look_tag = lookup_pc[31:2+BTB_W];
  assign upd_bi   = upd_pc[2 +: BTB_W];
  assign upd_tag  = upd_pc[31:2+BTB_W];

  // Word offsets are always zero on aligned fetch/update PCs.
  assign unused_ok = ^{lookup_pc[1:0], upd_pc[1:0]};

`ifdef FETCH_GSHARE_EN
  logic [HIST_W-1:0] ghr;

  // Global history only records resolved outcomes, never speculative ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd_vld) begin
      ghr <= {ghr[HIST_W-2:0], upd_taken};
    end
  end

  assign lookup_idx = lookup_pc[HIST_W+1:2] ^ ghr;
`else
  assign lookup_idx = lookup_pc[HIST_W+1:2];
`endif

  assign look_cnt      = pht[lookup_idx];
  assign btb_hit       = btb_vld[look_bi] && (btb_tag[look_bi] == look_tag);
  assign lookup_taken  = look_cnt[1] && btb_hit;
  assign lookup_target = btb_tgt[look_bi];

  // PHT counters start weakly not-taken and train on each resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht[i] <= WNT;
      end
    end else if (upd_vld) begin
      pht[upd_pattern] <= cnt_step(pht[upd_pattern], upd_taken);
    end
  end

  // BTB valid bits are the only BTB state that needs clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_vld <= '0;
    end else if (upd_vld && upd_taken) begin
      btb_vld[upd_bi] <= 1'b1;
    end
  end

  // Tag and target payload; meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && upd_vld && upd_taken) begin
      btb_tag[upd_bi] <= upd_tag;
      btb_tgt[upd_bi] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_cycle.sv
// IF stage of the 5-stage RV32I pipeline: PC register, next-PC selection and
// the IF/ID pipeline register. Branch prediction lives in bpred_gshare.
// Build option FETCH_GSHARE_EN selects gshare indexing in the predictor;
// undefined gives a bimodal predictor with no history register.
module fetch_cycle
  import riscv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          HIST_W      = PATTERN_W,
  parameter int          BTB_ENTRIES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall_F,
  input  logic              i_stall_D,
  input  logic              i_flush_D,
  input  logic              i_redirect_E,
  input  logic [31:0]       i_redirect_pc_E,
  input  logic              i_upd_vld_E,
  input  logic              i_upd_taken_E,
  input  logic [31:0]       i_upd_pc_E,
  input  logic [31:0]       i_upd_target_E,
  input  logic [HIST_W-1:0] i_upd_pattern_E,
  output logic [31:0]       o_imem_addr,
  input  logic [31:0]       i_imem_rdata,
  output logic [31:0]       o_pc_D,
  output logic [31:0]       o_pc_4_D,
  output logic [31:0]       o_instr_D,
  output logic [HIST_W-1:0] o_pattern_D,
  output logic              o_pred_taken_D
);

  logic [31:0]       pc;
  logic [31:0]       pc_4;
  logic [31:0]       pc_next;
  logic [HIST_W-1:0] pred_idx;
  logic              pred_taken;
  logic [31:0]       pred_target;

  bpred_gshare #(
    .HIST_W      (HIST_W),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_bpred (
    .clk           (i_clk),
    .rst           (i_rst),
    .lookup_pc     (pc),
    .lookup_idx    (pred_idx),
    .lookup_taken  (pred_taken),
    .lookup_target (pred_target),
    .upd_vld       (i_upd_vld_E),
    .upd_taken     (i_upd_taken_E),
    .upd_pc        (i_upd_pc_E),
    .upd_target    (i_upd_target_E),
    .upd_pattern   (i_upd_pattern_E)
  );

  assign pc_4        = pc + 32'd4;
  assign o_imem_addr = pc;

  // Next PC: EX correction beats a fetch stall, which beats the prediction.
  always_comb begin
    pc_next = pc_4;
    if (i_redirect_E) begin
      pc_next = i_redirect_pc_E;
    end else if (i_stall_F) begin
      pc_next = pc;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // IF/ID register: a flush inserts the same bubble as reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush_D) begin
      o_pc_D         <= '0;
      o_pc_4_D       <= '0;
      o_instr_D      <= NOP_INSTR;
      o_pattern_D    <= '0;
      o_pred_taken_D <= 1'b0;
    end else if (!i_stall_D) begin
      o_pc_D         <= pc;
      o_pc_4_D       <= pc_4;
      o_instr_D      <= i_imem_rdata;
      o_pattern_D    <= pred_idx;
      o_pred_taken_D <= pred_taken;
    end
  end

endmodule
